alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
// - Execute-stage datapath slice for the single-cycle MIPS core.
// - Decodes the 2-bit main-control ALUOp plus the instruction funct field into a 4-bit ALU operation.
// - Performs the 32-bit ALU operation and raises zero/overflow flags.
// - ANDs the branch control with zero to produce the PCSrc select. Result and flags are registered (1-cycle latency).
// PARAMETERS
// - WIDTH  32  datapath width of a, b, result
// PORTS
// - clk             in   1      rising-edge clock
// - rst_n           in   1      asynchronous active-low reset
// - alu_op          in   2      ALUOp from main control (00 ld/st, 01 beq, 10 R-type, 11 reserved)
// - func_code       in   6      instruction bits [5:0]
// - op_override_en  in   1      1: use op_override directly, bypass decode (PC+4 / branch adders)
// - op_override     in   4      direct ALU operation code
// - branch          in   1      branch control from main control
// - a               in   WIDTH  operand A (rs content / PC)
// - b               in   WIDTH  operand B (ALUSrc mux output)
// - alu_ctrl        out  4      decoded operation, combinational
// - result          out  WIDTH  registered ALU result
// - zero            out  1      registered, 1 when result == 0
// - overflow        out  1      registered signed overflow (ADD/SUB only, else 0)
// - branch_taken    out  1      registered branch & zero
// BEHAVIOUR
// - Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR.
// - Any other 4-bit code yields result 0, overflow 0.
// - Decode: alu_op 00 -> ADD; 01 -> SUB; 11 -> ADD.
// - Decode alu_op 10 by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR.
// - Decode alu_op 10, any other funct -> ADD.
// - op_override_en=1 takes priority over decode; alu_ctrl shows the selected code.
// - Arithmetic is modulo 2^WIDTH; carry out is discarded.
// - SLT result is 32'd1 if $signed(a) < $signed(b), else 32'd0.
// - Overflow on ADD: operand signs equal and result sign differs.
// - Overflow on SUB: operand signs differ and result sign differs from a. Overflow is a flag only, never a trap.
// - zero and branch_taken are computed from the same-cycle combinational result, then registered with result.
// - Latency: inputs sampled at rising clk edge; outputs valid after that edge; a new op is accepted every cycle.
// - Reset (rst_n=0, asynchronous): result=0, zero=1, overflow=0, branch_taken=0. Held while rst_n is low.
// - Reset deassertion is synchronised by the system; the first edge after release loads normally.
// - alu_ctrl is combinational and unaffected by reset.
// - Reset mid-operation discards the in-flight result; no partial update.
// STRUCTURE
// - Shared package: ALU op localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR).
// - Shared package: ALUOp codes and funct constants.
// - One sub-module, alu_ctrl_dec: purely combinational alu_op/func_code -> 4-bit op.
// - ALU core, flag logic, branch AND and output register live in the top.
// TESTING
// - Reset: rst_n=0 mid-run -> result=0, zero=1, overflow=0, branch_taken=0 immediately (no clock needed).
// - R-type: alu_op=10, funct=100000, a=7, b=5 -> result=12, zero=0.
// - R-type: funct=100010, a=5, b=7 -> result=32'hFFFFFFFE, zero=0.
// - R-type: funct=101010, a=32'hFFFFFFFF, b=1 -> result=1. funct=100111, a=b=0 -> result=32'hFFFFFFFF.
// - beq: alu_op=01, branch=1, a=b=32'h1234 -> result=0, zero=1, branch_taken=1.
// - beq: same with a=1, b=2 -> branch_taken=0. branch=0, a=b -> branch_taken=0.
// - Overflow: override 0010, a=32'h7FFFFFFF, b=1 -> result=32'h80000000, overflow=1.
// - Overflow: override 0110, a=32'h80000000, b=1 -> overflow=1.
// - PC adder: op_override_en=1, op_override=0010, a=8, b=1 -> result=9, regardless of alu_op/func_code.
// - Unknown funct: alu_op=10, funct=000000 -> alu_ctrl=0010.
// - Illegal op: override 1111 -> result=0, zero=1.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
// Shared constants for the execute stage: ALU operation codes, main-control
// ALUOp encodings and the R-type funct values the decoder recognises.
package alu_exec_stage_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_exec_stage_ctrl_dec.sv
// ALU control decoder: maps main-control ALUOp and the funct field to a
// 4-bit ALU operation. Purely combinational.
module alu_ctrl_dec
  import alu_exec_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] func_code,
  output logic [3:0] aluCtrl
);

  always_comb begin
    // NOTE: default assignment first so every path drives aluCtrl; no latch.
    aluCtrl = ALU_ADD;
    unique case (alu_op)
      ALUOP_LDST:  aluCtrl = ALU_ADD;
      ALUOP_BEQ:   aluCtrl = ALU_SUB;
      ALUOP_RSVD:  aluCtrl = ALU_ADD;
      ALUOP_RTYPE: begin
        case (func_code)
          FUNCT_ADD: aluCtrl = ALU_ADD;
          FUNCT_SUB: aluCtrl = ALU_SUB;
          FUNCT_AND: aluCtrl = ALU_AND;
          FUNCT_OR:  aluCtrl = ALU_OR;
          FUNCT_SLT: aluCtrl = ALU_SLT;
          FUNCT_NOR: aluCtrl = ALU_NOR;
          default:   aluCtrl = ALU_ADD;
        endcase
      end
      default: aluCtrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage of the single-cycle MIPS core: ALU control select, 32-bit ALU,
// zero/overflow flags and branch decision, all registered with one-cycle latency.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func_code,
  input  logic             op_override_en,
  input  logic [3:0]       op_override,
  input  logic             branch,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             branch_taken
);

  logic [3:0]       decodedCtrl;
  logic [WIDTH-1:0] sumVal;
  logic [WIDTH-1:0] diffVal;
  logic [WIDTH-1:0] nextResult;
  logic             nextOverflow;
  logic             nextZero;
  logic             signA;
  logic             signB;

  alu_ctrl_dec uCtrlDec (
    .alu_op    (alu_op),
    .func_code (func_code),
    .aluCtrl   (decodedCtrl)
  );

  // Adders for PC+4 and branch targets drive the operation directly.
  assign alu_ctrl = op_override_en ? op_override : decodedCtrl;

  assign sumVal  = a + b;
  assign diffVal = a - b;
  assign signA   = a[WIDTH-1];
  assign signB   = b[WIDTH-1];

  always_comb begin
    nextResult   = '0;
    nextOverflow = 1'b0;
    case (alu_ctrl)
      ALU_AND: nextResult = a & b;
      ALU_OR:  nextResult = a | b;
      ALU_NOR: nextResult = ~(a | b);
      ALU_ADD: begin
        nextResult   = sumVal;
        nextOverflow = (signA == signB) && (sumVal[WIDTH-1] != signA);
      end
      ALU_SUB: begin
        nextResult   = diffVal;
        nextOverflow = (signA != signB) && (diffVal[WIDTH-1] != signA);
      end
      ALU_SLT: nextResult = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: begin
        nextResult   = '0;
        nextOverflow = 1'b0;
      end
    endcase
  end

  assign nextZero = (nextResult == '0);

  // NOTE: sequential state uses non-blocking assignments so all four outputs
  // update together from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      zero         <= 1'b1;
      overflow     <= 1'b0;
      branch_taken <= 1'b0;
    end else begin
      result       <= nextResult;
      zero         <= nextZero;
      overflow     <= nextOverflow;
      branch_taken <= branch & nextZero;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage with hand-computed vectors.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst_n;
  logic [1:0]  alu_op;
  logic [5:0]  func_code;
  logic        op_override_en;
  logic [3:0]  op_override;
  logic        branch;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        branch_taken;

  int checkCount = 0;
  int errorCount = 0;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_op         (alu_op),
    .func_code      (func_code),
    .op_override_en (op_override_en),
    .op_override    (op_override),
    .branch         (branch),
    .a              (a),
    .b              (b),
    .alu_ctrl       (alu_ctrl),
    .result         (result),
    .zero           (zero),
    .overflow       (overflow),
    .branch_taken   (branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the capturing rising edge.
  task automatic runOp(input logic [1:0] op, input logic [5:0] fn, input logic ovEn,
                       input logic [3:0] ov, input logic br,
                       input logic [31:0] opA, input logic [31:0] opB);
    @(negedge clk);
    alu_op = op; func_code = fn; op_override_en = ovEn; op_override = ov;
    branch = br; a = opA; b = opB;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_op = 2'b00; func_code = 6'b0; op_override_en = 1'b0; op_override = 4'b0;
    branch = 1'b0; a = 32'd0; b = 32'd0;

    #12;
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_bt", {31'd0, branch_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp(2'b10, 6'b100000, 1'b0, 4'h0, 1'b0, 32'd7, 32'd5);
    check("radd_ctrl", {28'd0, alu_ctrl}, 32'h2);
    check("radd_result", result, 32'd12);
    check("radd_zero", {31'd0, zero}, 32'd0);
    check("radd_ovf", {31'd0, overflow}, 32'd0);

    runOp(2'b10, 6'b100010, 1'b0, 4'h0, 1'b0, 32'd5, 32'd7);
    check("rsub_ctrl", {28'd0, alu_ctrl}, 32'h6);
    check("rsub_result", result, 32'hFFFF_FFFE);
    check("rsub_zero", {31'd0, zero}, 32'd0);

    runOp(2'b10, 6'b101010, 1'b0, 4'h0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    check("rslt_ctrl", {28'd0, alu_ctrl}, 32'h7);
    check("rslt_result", result, 32'd1);

    runOp(2'b10, 6'b101010, 1'b0, 4'h0, 1'b0, 32'd1, 32'hFFFF_FFFF);
    check("rslt_false", result, 32'd0);

    runOp(2'b10, 6'b100111, 1'b0, 4'h0, 1'b0, 32'd0, 32'd0);
    check("rnor_ctrl", {28'd0, alu_ctrl}, 32'hC);
    check("rnor_result", result, 32'hFFFF_FFFF);

    runOp(2'b10, 6'b100100, 1'b0, 4'h0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00);
    check("rand_result", result, 32'h0000_F000);
    runOp(2'b10, 6'b100101, 1'b0, 4'h0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00);
    check("ror_result", result, 32'h0000_FFF0);

    runOp(2'b01, 6'b000000, 1'b0, 4'h0, 1'b1, 32'h1234, 32'h1234);
    check("beq_ctrl", {28'd0, alu_ctrl}, 32'h6);
    check("beq_result", result, 32'd0);
    check("beq_zero", {31'd0, zero}, 32'd1);
    check("beq_taken", {31'd0, branch_taken}, 32'd1);

    runOp(2'b01, 6'b000000, 1'b0, 4'h0, 1'b1, 32'd1, 32'd2);
    check("beq_ne_taken", {31'd0, branch_taken}, 32'd0);
    check("beq_ne_zero", {31'd0, zero}, 32'd0);

    runOp(2'b01, 6'b000000, 1'b0, 4'h0, 1'b0, 32'h1234, 32'h1234);
    check("nobr_taken", {31'd0, branch_taken}, 32'd0);
    check("nobr_zero", {31'd0, zero}, 32'd1);

    runOp(2'b00, 6'b100010, 1'b1, 4'b0010, 1'b0, 32'h7FFF_FFFF, 32'd1);
    check("addovf_result", result, 32'h8000_0000);
    check("addovf_ovf", {31'd0, overflow}, 32'd1);

    runOp(2'b00, 6'b000000, 1'b1, 4'b0110, 1'b0, 32'h8000_0000, 32'd1);
    check("subovf_result", result, 32'h7FFF_FFFF);
    check("subovf_ovf", {31'd0, overflow}, 32'd1);

    runOp(2'b00, 6'b000000, 1'b1, 4'b0110, 1'b0, 32'd1, 32'h8000_0000);
    check("subovf_neg_ovf", {31'd0, overflow}, 32'd1);

    runOp(2'b10, 6'b100010, 1'b1, 4'b0010, 1'b0, 32'd8, 32'd1);
    check("pcadd_ctrl", {28'd0, alu_ctrl}, 32'h2);
    check("pcadd_result", result, 32'd9);
    check("pcadd_ovf", {31'd0, overflow}, 32'd0);

    runOp(2'b10, 6'b000000, 1'b0, 4'h0, 1'b0, 32'd3, 32'd4);
    check("unkfn_ctrl", {28'd0, alu_ctrl}, 32'h2);
    check("unkfn_result", result, 32'd7);

    runOp(2'b11, 6'b100010, 1'b0, 4'h0, 1'b0, 32'd10, 32'd20);
    check("rsvd_ctrl", {28'd0, alu_ctrl}, 32'h2);
    check("rsvd_result", result, 32'd30);

    runOp(2'b00, 6'b100010, 1'b0, 4'h0, 1'b0, 32'd100, 32'd4);
    check("ldst_result", result, 32'd104);

    runOp(2'b00, 6'b000000, 1'b1, 4'b0110, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    runOp(2'b00, 6'b000000, 1'b1, 4'b1111, 1'b1, 32'h8000_0000, 32'h8000_0000);
    check("illegal_ctrl", {28'd0, alu_ctrl}, 32'hF);
    check("illegal_result", result, 32'd0);
    check("illegal_zero", {31'd0, zero}, 32'd1);
    check("illegal_ovf", {31'd0, overflow}, 32'd0);
    check("illegal_bt", {31'd0, branch_taken}, 32'd1);

    // Asynchronous reset mid-run, away from any clock edge.
    runOp(2'b00, 6'b000000, 1'b1, 4'b0010, 1'b0, 32'h7FFF_FFFF, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd1);
    check("midrst_ovf", {31'd0, overflow}, 32'd0);
    check("midrst_ctrl", {28'd0, alu_ctrl}, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;

    runOp(2'b01, 6'b000000, 1'b0, 4'h0, 1'b1, 32'd5, 32'd5);
    check("pre_rst_bt", {31'd0, branch_taken}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_bt", {31'd0, branch_taken}, 32'd0);

    // Reset held across a clock edge with a live operation on the inputs.
    runOp(2'b10, 6'b100000, 1'b0, 4'h0, 1'b0, 32'd7, 32'd5);
    check("hold_rst_result", result, 32'd0);
    check("hold_rst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    runOp(2'b10, 6'b100000, 1'b0, 4'h0, 1'b0, 32'd21, 32'd21);
    check("post_rst_result", result, 32'd42);
    check("post_rst_zero", {31'd0, zero}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
